// File: rtl/ttr_pkg.sv
// Shared TTR definitions: phase encoding for the ctr bus and default widths
// used by the voter controller and the TTR flip-flop chains.
package ttr_pkg;

    typedef enum logic [1:0] {
        TTR_PH0 = 2'd0,
        TTR_PH1 = 2'd1,
        TTR_PH2 = 2'd2
    } ttr_phase_t;

    localparam int TTR_WIDTH_DEF     = 8;
    localparam int TTR_ERR_CNT_W_DEF = 8;

endpackage

// File: rtl/ttr_maj3.sv
// Bitwise 2-of-3 majority voter with a word-level disagreement flag.
module ttr_maj3 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] maj,
    output logic             disagree
);

    assign maj      = (a & b) | (a & c) | (b & c);
    assign disagree = |((a ^ b) | (a ^ c));

endmodule

// File: rtl/ttr_vote_ctrl.sv
// TTR consumer: drives the phase bus, captures three time-redundant samples and
// emits their majority vote. Macro TTR_UNCORR_DET_EN adds the uncorr output.
module ttr_vote_ctrl
    import ttr_pkg::*;
#(
    parameter int WIDTH     = TTR_WIDTH_DEF,
    parameter int ERR_CNT_W = TTR_ERR_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [WIDTH-1:0]     inD,
    output logic [1:0]           ctr,
    output logic [WIDTH-1:0]     outD,
    output logic                 outValid,
    output logic                 mismatch,
    output logic [ERR_CNT_W-1:0] errCnt,
    input  logic                 errClr
`ifdef TTR_UNCORR_DET_EN
    ,
    output logic                 uncorr
`endif
);

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    ttr_phase_t       state, state_nxt;
    logic             cap0, cap1, vote;
    logic [WIDTH-1:0] s0, s1;
    logic [WIDTH-1:0] maj_w;
    logic             disagree_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= TTR_PH0;
        else        state <= state_nxt;
    end

    // Dropping en anywhere restarts the frame at PH0.
    always_comb begin
        state_nxt = TTR_PH0;
        if (en) begin
            case (state)
                TTR_PH0: state_nxt = TTR_PH1;
                TTR_PH1: state_nxt = TTR_PH2;
                default: state_nxt = TTR_PH0;
            endcase
        end
    end

    always_comb begin
        cap0 = 1'b0;
        cap1 = 1'b0;
        vote = 1'b0;
        case (state)
            TTR_PH0: cap0 = en;
            TTR_PH1: cap1 = en;
            TTR_PH2: vote = en;
            default: ;
        endcase
    end

    assign ctr = state;

    // The third sample is voted straight from inD; it is never stored.
    ttr_maj3 #(.WIDTH(WIDTH)) u_maj3 (
        .a        (s0),
        .b        (s1),
        .c        (inD),
        .maj      (maj_w),
        .disagree (disagree_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0       <= '0;
            s1       <= '0;
            outD     <= '0;
            outValid <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            if (cap0) s0 <= inD;
            if (cap1) s1 <= inD;
            if (vote) outD <= maj_w;
            outValid <= vote;
            mismatch <= vote & disagree_w;
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  errCnt <= '0;
        else if (errClr)             errCnt <= '0;
        else if (vote && disagree_w) errCnt <= sat_inc(errCnt);
    end

`ifdef TTR_UNCORR_DET_EN
    logic all_differ;
    assign all_differ = (s0 != s1) && (s0 != inD) && (s1 != inD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) uncorr <= 1'b0;
        else        uncorr <= vote & all_differ;
    end
`endif

endmodule

// File: doc/ttr_vote_ctrl.md
Name: ttr_vote_ctrl

Overview:
- Consumer end of the triple-time-redundancy (TTR) datapath.
- Drives the 2-bit phase control (`ctr`) that TTR flip-flop chains consume.
- Captures the three time-redundant samples of one data word and emits the bitwise 2-of-3 majority with a valid strobe.
- Flags any disagreement between samples and counts mismatching frames for fault monitoring.

Parameters:
- WIDTH, 8, data word width in bits (min 1).
- ERR_CNT_W, 8, width of the saturating mismatch-frame counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous reset, active-low.
- en  in  1  frame enable; phases advance only while high.
- inD  in  WIDTH  redundant data sample, one per phase.
- ctr  out  2  current phase: 0, 1, 2 (value 3 never driven).
- outD  out  WIDTH  voted word, registered.
- outValid  out  1  one-cycle pulse when outD updates.
- mismatch  out  1  one-cycle pulse coincident with outValid if any sample bit disagreed.
- errCnt  out  ERR_CNT_W  count of mismatching frames, saturating.
- errClr  in  1  synchronous clear of errCnt.

Behaviour:
- Reset (async assert, sync-safe release): ctr=0, outD=0, outValid=0, mismatch=0, errCnt=0, sample regs s0/s1=0.
- Phase FSM states PH0, PH1, PH2 (encoded 0, 1, 2); ctr is the state register directly.
  - en=1: PH0->PH1->PH2->PH0, one step per clock.
  - en=0 in any state: next state is PH0. A partially captured frame is discarded with no outValid. s0/s1 keep stale values but are never used unless recaptured.
- Capture:
  - In PH0 with en=1, s0<=inD.
  - In PH1 with en=1, s1<=inD.
  - In PH2 with en=1, inD is used directly as the third sample s2. No s2 register.
- Vote at the PH2 clock edge with en=1:
  - outD<=maj(s0,s1,inD) bitwise, i.e. (a&b)|(a&c)|(b&c).
  - outValid<=1.
  - mismatch<=|((s0^s1)|(s0^inD)).
- outValid and mismatch are 0 in every other cycle. outD holds its last voted value.
- Latency: outValid is high in the cycle after PH2, which is the same cycle ctr returns to 0. With continuous en, throughput is one word per 3 cycles.
- errCnt:
  - Increments by 1 on each mismatching frame (same edge as mismatch<=1).
  - Saturates at all-ones; no wrap.
- errClr:
  - errClr=1 forces errCnt<=0, with priority over an increment in the same cycle.
  - The mismatch pulse is unaffected by errClr.
- en dropping exactly in PH2: no vote, and the frame is lost. en must be high on the PH2 edge for a vote.
- Reset asserted mid-frame: immediate return to reset values; any pending vote is lost.

Optional Feature:
- Macro: TTR_UNCORR_DET_EN.
- Defined:
  - Adds output port `uncorr` (1 bit), which pulses with outValid.
  - `uncorr` is high when all three words are pairwise unequal (s0!=s1, s0!=inD, s1!=inD), meaning the word-level vote is not trustworthy.
  - outD is still the bitwise majority.
  - For WIDTH=1, `uncorr` is constant 0.
- Undefined: port `uncorr` and its logic are absent. All other behaviour is identical.

Decomposition:
- Package ttr_pkg:
  - Phase typedef (2-bit) with constants TTR_PH0=2'd0, TTR_PH1=2'd1, TTR_PH2=2'd2.
  - Default width constants shared with the TTR flip-flop chains.
- Sub-module ttr_maj3:
  - Purely combinational, parameter WIDTH.
  - Inputs a, b, c; outputs maj and disagree.
  - Reused by other TTR voters.
- FSM, capture registers and counter live in ttr_vote_ctrl.

Test Plan:
- Reset then en=1, inD=0xA5 for 3 cycles -> ctr sequence 0,1,2,0; outD=0xA5 and outValid=1 in cycle 4; mismatch=0; errCnt=0.
- Samples 0xA5, 0xA4, 0xA5 -> outD=0xA5, mismatch=1, errCnt=1. Repeat 300 frames with ERR_CNT_W=8 -> errCnt saturates at 255.
- en=1 for PH0/PH1, then en=0 on the PH2 cycle -> no outValid, ctr=0 next cycle, outD unchanged. A following clean frame of 0x3C -> outD=0x3C.
- errClr=1 on the same cycle as a mismatching vote -> errCnt=0, mismatch pulse still 1.
- rst_n low during PH1 -> ctr=0, outValid=0, errCnt=0 immediately, without waiting for a clock edge.
- With TTR_UNCORR_DET_EN, samples 0x01, 0x02, 0x04 -> outD=0x00, mismatch=1, uncorr=1. Samples 0x01, 0x01, 0x04 -> uncorr=0.
